// File: rtl/opsga_pkg.sv
// Shared definitions for the OPSGA endmember-search datapath: beat sizing,
// score-mode encoding and the argmax engine's state type.
package opsga_pkg;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int beats_per_pixel(input int bands, input int lanes);
        return ceil_div(bands, lanes);
    endfunction

    localparam logic MODE_NORM = 1'b0;
    localparam logic MODE_DOT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_OUT
    } state_e;

endpackage

// File: rtl/proj_argmax_engine_lane_mac.sv
// Two-stage lane multiplier: stage 1 registers the masked per-lane products,
// stage 2 registers their sign-extended sum. Each stage carries a valid bit.
module lane_mac
    import opsga_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 40
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          valid_i,
    input  logic                          first_i,
    input  logic                          last_i,
    input  logic                          mode_i,
    input  logic [LANES-1:0]              keep_i,
    input  logic [LANES*IN_WIDTH-1:0]     pixel_i,
    input  logic [LANES*IN_WIDTH-1:0]     weight_i,
    output logic                          valid_o,
    output logic                          first_o,
    output logic                          last_o,
    output logic signed [ACC_WIDTH-1:0]   sum_o
);
    localparam int PROD_W = 2 * IN_WIDTH;

    logic signed [IN_WIDTH-1:0]  lhs    [LANES];
    logic signed [IN_WIDTH-1:0]  rhs    [LANES];
    logic signed [PROD_W-1:0]    prod_d [LANES];
    logic signed [PROD_W-1:0]    prod_q [LANES];
    logic signed [ACC_WIDTH-1:0] tree_d;
    logic signed [ACC_WIDTH-1:0] sum_q;
    logic s1_valid_q, s1_first_q, s1_last_q;
    logic s2_valid_q, s2_first_q, s2_last_q;

    // Masked lanes are zeroed before the multiplier, so their weight never matters.
    always_comb begin
        tree_d = '0;
        for (int l = 0; l < LANES; l++) begin
            lhs[l]    = keep_i[l] ? pixel_i[l*IN_WIDTH +: IN_WIDTH] : '0;
            rhs[l]    = (mode_i == MODE_DOT) ? weight_i[l*IN_WIDTH +: IN_WIDTH] : lhs[l];
            prod_d[l] = PROD_W'(lhs[l]) * PROD_W'(rhs[l]);
            tree_d    = tree_d + ACC_WIDTH'(prod_q[l]);
        end
    end

    // NOTE: only the valid bits need reset; data registers are qualified by them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else if (flush_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= valid_i;
            s2_valid_q <= s1_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (valid_i) begin
            prod_q     <= prod_d;
            s1_first_q <= first_i;
            s1_last_q  <= last_i;
        end
        if (s1_valid_q) begin
            sum_q      <= tree_d;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
        end
    end

    assign valid_o = s2_valid_q;
    assign first_o = s2_first_q;
    assign last_o  = s2_last_q;
    assign sum_o   = sum_q;

endmodule

// File: rtl/proj_argmax_engine.sv
// Streaming per-pixel scorer (squared norm or dot product) with a running
// argmax over one image pass and a backpressured result handshake.
module proj_argmax_engine
    import opsga_pkg::*;
#(
    parameter int IN_WIDTH       = 16,
    parameter int LANES          = 4,
    parameter int SPECTRAL_BANDS = 188,
    parameter int TOTAL_PIXELS   = 47500,
    parameter int ACC_WIDTH      = 40
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              mode,
    input  logic                              clear,
    input  logic [LANES*IN_WIDTH-1:0]         pixel_in,
    input  logic [LANES*IN_WIDTH-1:0]         weight_in,
    input  logic                              pixel_valid,
    output logic                              pixel_ready,
    output logic [$clog2(TOTAL_PIXELS)-1:0]   idx_out,
    output logic [ACC_WIDTH-1:0]              max_out,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              done
);
    localparam int BEATS      = beats_per_pixel(SPECTRAL_BANDS, LANES);
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W      = $clog2(TOTAL_PIXELS);
    localparam int TAIL_BANDS = SPECTRAL_BANDS - (BEATS - 1) * LANES;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  PIX_LAST  = IDX_W'(TOTAL_PIXELS - 1);

    state_e                      state_q;
    logic                        mode_q;
    logic                        drain_q;
    logic [BEAT_W-1:0]           beat_q;
    logic [IDX_W-1:0]            pix_q;
    logic [IDX_W-1:0]            score_cnt_q;
    logic [IDX_W-1:0]            idx_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] max_q;
    logic                        hs, beat_last, pix_last;
    logic [LANES-1:0]            keep;
    logic                        s2_valid, s2_first, s2_last;
    logic signed [ACC_WIDTH-1:0] s2_sum;

    assign hs        = pixel_valid & pixel_ready;
    assign beat_last = (beat_q == BEAT_LAST);
    assign pix_last  = (pix_q == PIX_LAST);

    always_comb begin
        keep = '1;
        if (beat_last) begin
            for (int l = 0; l < LANES; l++) begin
                if (l >= TAIL_BANDS) keep[l] = 1'b0;
            end
        end
    end

    lane_mac #(
        .IN_WIDTH  (IN_WIDTH),
        .LANES     (LANES),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_lane_mac (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (clear),
        .valid_i  (hs),
        .first_i  (beat_q == '0),
        .last_i   (beat_last),
        .mode_i   (mode_q),
        .keep_i   (keep),
        .pixel_i  (pixel_in),
        .weight_i (weight_in),
        .valid_o  (s2_valid),
        .first_o  (s2_first),
        .last_o   (s2_last),
        .sum_o    (s2_sum)
    );

    assign acc_d = s2_first ? s2_sum : acc_q + s2_sum;

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_NORM;
            drain_q <= 1'b0;
            beat_q  <= '0;
            pix_q   <= '0;
        end else if (clear) begin
            state_q <= ST_IDLE;
            drain_q <= 1'b0;
            beat_q  <= '0;
            pix_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_q <= ST_RUN;
                    mode_q  <= mode;
                    beat_q  <= '0;
                    pix_q   <= '0;
                end
                ST_RUN: if (hs) begin
                    if (beat_last) begin
                        beat_q <= '0;
                        pix_q  <= pix_last ? '0 : pix_q + 1'b1;
                        if (pix_last) begin
                            state_q <= ST_DRAIN;
                            drain_q <= 1'b0;
                        end
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                // Two cycles let the final beat clear both pipeline stages.
                ST_DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) state_q <= ST_OUT;
                end
                ST_OUT: if (out_ready) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            score_cnt_q <= '0;
        end else if (clear || (state_q == ST_IDLE && start)) begin
            score_cnt_q <= '0;
        end else if (s2_valid) begin
            acc_q <= acc_d;
            if (s2_last) begin
                score_cnt_q <= score_cnt_q + 1'b1;
                // Strictly greater keeps the lower index on ties.
                if (score_cnt_q == '0 || acc_d > max_q) begin
                    max_q <= acc_d;
                    idx_q <= score_cnt_q;
                end
            end
        end
    end

    assign pixel_ready = (state_q == ST_RUN);
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = (state_q == ST_OUT);
    assign done        = out_valid & out_ready & ~clear;
    assign idx_out     = idx_q;
    assign max_out     = max_q;

endmodule

// File: tb/tb_proj_argmax_engine.sv
// Directed and randomized passes through a 6-band, 3-pixel argmax engine,
// checked against a plain-arithmetic score/argmax model.
module tb_proj_argmax_engine;
    localparam int IN_WIDTH       = 16;
    localparam int LANES          = 4;
    localparam int SPECTRAL_BANDS = 6;
    localparam int TOTAL_PIXELS   = 3;
    localparam int ACC_WIDTH      = 40;
    localparam int BEATS          = (SPECTRAL_BANDS + LANES - 1) / LANES;
    localparam int SLOTS          = BEATS * LANES;
    localparam int IDX_W          = $clog2(TOTAL_PIXELS);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic clear = 1'b0;
    logic pixel_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [LANES*IN_WIDTH-1:0] pixel_in = '0;
    logic [LANES*IN_WIDTH-1:0] weight_in = '0;
    logic pixel_ready, out_valid, busy, done;
    logic [IDX_W-1:0]     idx_out;
    logic [ACC_WIDTH-1:0] max_out;

    int pix [TOTAL_PIXELS][SLOTS];
    int wt  [TOTAL_PIXELS][SLOTS];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    proj_argmax_engine #(
        .IN_WIDTH       (IN_WIDTH),
        .LANES          (LANES),
        .SPECTRAL_BANDS (SPECTRAL_BANDS),
        .TOTAL_PIXELS   (TOTAL_PIXELS),
        .ACC_WIDTH      (ACC_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .clear       (clear),
        .pixel_in    (pixel_in),
        .weight_in   (weight_in),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .idx_out     (idx_out),
        .max_out     (max_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Score uses only real bands; tail slots are never part of the sum.
    function automatic longint model_score(input int p, input bit m);
        longint s = 0;
        for (int b = 0; b < SPECTRAL_BANDS; b++)
            s += longint'(pix[p][b]) * longint'(m ? wt[p][b] : pix[p][b]);
        return s;
    endfunction

    function automatic int model_best(input bit m);
        int best = 0;
        for (int p = 1; p < TOTAL_PIXELS; p++)
            if (model_score(p, m) > model_score(best, m)) best = p;
        return best;
    endfunction

    task automatic fill_uniform(input int v0, input int v1, input int v2, input int w, input int tail);
        int v [TOTAL_PIXELS];
        v[0] = v0; v[1] = v1; v[2] = v2;
        for (int p = 0; p < TOTAL_PIXELS; p++)
            for (int s = 0; s < SLOTS; s++) begin
                pix[p][s] = (s < SPECTRAL_BANDS) ? v[p] : tail;
                wt[p][s]  = (s < SPECTRAL_BANDS) ? w : tail;
            end
    endtask

    task automatic fill_random();
        for (int p = 0; p < TOTAL_PIXELS; p++)
            for (int s = 0; s < SLOTS; s++) begin
                pix[p][s] = int'($urandom_range(65535)) - 32768;
                wt[p][s]  = int'($urandom_range(65535)) - 32768;
            end
    endtask

    task automatic send_beat(input int p, input int b);
        int waited = 0;
        int v, w;
        for (int l = 0; l < LANES; l++) begin
            v = pix[p][b*LANES + l];
            w = wt[p][b*LANES + l];
            pixel_in[l*IN_WIDTH +: IN_WIDTH]  = v[IN_WIDTH-1:0];
            weight_in[l*IN_WIDTH +: IN_WIDTH] = w[IN_WIDTH-1:0];
        end
        pixel_valid = 1'b1;
        while (!pixel_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("pixel_ready_in_run", 64'(pixel_ready), 64'(1));
        @(negedge clk);
        pixel_valid = 1'b0;
    endtask

    task automatic begin_pass(input bit m);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = 1'b0;
    endtask

    task automatic run_pass(input bit m, input int gap_pct, input bit do_ack, input string tag);
        logic [IDX_W-1:0]     exp_idx;
        logic [ACC_WIDTH-1:0] exp_max;
        int best, lat;
        best    = model_best(m);
        exp_idx = IDX_W'(best);
        exp_max = ACC_WIDTH'(model_score(best, m));
        begin_pass(m);
        check({tag, "_busy"}, 64'(busy), 64'(1));
        for (int p = 0; p < TOTAL_PIXELS; p++)
            for (int b = 0; b < BEATS; b++) begin
                if ($urandom_range(99) < gap_pct) repeat ($urandom_range(3, 1)) @(negedge clk);
                send_beat(p, b);
            end
        check({tag, "_drain_ready"}, 64'(pixel_ready), 64'(0));
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(3));
        check({tag, "_idx"}, 64'(idx_out), 64'(exp_idx));
        check({tag, "_max"}, 64'(max_out), 64'(exp_max));
        if (do_ack) begin
            out_ready = 1'b1;
            #1;
            check({tag, "_done"}, 64'(done), 64'(1));
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            check({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
            check({tag, "_idle"}, 64'(busy), 64'(0));
            check({tag, "_idx_hold"}, 64'(idx_out), 64'(exp_idx));
            check({tag, "_max_hold"}, 64'(max_out), 64'(exp_max));
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [IDX_W-1:0]     bp_idx;
        logic [ACC_WIDTH-1:0] bp_max;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_idx", 64'(idx_out), 64'(0));
        check("rst_max", 64'(max_out), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_pixel_ready", 64'(pixel_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios
        fill_uniform(1, 2, 3, 0, 0);
        run_pass(1'b0, 0, 1'b1, "norm");
        fill_uniform(5, 5, 5, 0, 0);
        run_pass(1'b0, 0, 1'b1, "tie");
        fill_uniform(1, 2, 3, 0, 32767);
        run_pass(1'b0, 0, 1'b1, "tail");
        fill_uniform(1, 2, 3, -1, 0);
        run_pass(1'b1, 0, 1'b1, "dot");
        fill_uniform(1, 2, 3, -1, 32767);
        run_pass(1'b1, 0, 1'b1, "dot_tail");

        // Same scenarios with input gaps
        fill_uniform(1, 2, 3, 0, 0);
        run_pass(1'b0, 50, 1'b1, "norm_gaps");
        fill_uniform(5, 5, 5, 0, 0);
        run_pass(1'b0, 50, 1'b1, "tie_gaps");
        fill_uniform(1, 2, 3, -1, 0);
        run_pass(1'b1, 50, 1'b1, "dot_gaps");

        // Randomized passes
        repeat (8) begin
            fill_random();
            run_pass(1'($urandom_range(1, 0)), 40, 1'b1, "rand");
        end

        // Output backpressure with start held
        fill_uniform(1, 2, 3, 0, 0);
        run_pass(1'b0, 0, 1'b0, "bp");
        bp_idx = idx_out;
        bp_max = max_out;
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            #1;
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_pixel_ready", 64'(pixel_ready), 64'(0));
            check("bp_done_low", 64'(done), 64'(0));
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_done", 64'(done), 64'(1));
        check("bp_idx_stable", 64'(idx_out), 64'(bp_idx));
        check("bp_max_stable", 64'(max_out), 64'(bp_max));
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("bp_done_once", 64'(done), 64'(0));
        check("bp_start_ignored", 64'(busy), 64'(0));
        @(negedge clk);

        // Clear during pixel 1
        fill_uniform(1, 2, 3, 0, 0);
        begin_pass(1'b0);
        send_beat(0, 0);
        send_beat(0, 1);
        send_beat(1, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_busy", 64'(busy), 64'(0));
        check("clr_pixel_ready", 64'(pixel_ready), 64'(0));
        seen = 0;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid || done || busy) seen++;
        end
        out_ready = 1'b0;
        check("clr_no_result", 64'(seen), 64'(0));
        fill_random();
        run_pass(1'b0, 20, 1'b1, "post_clear");

        // Asynchronous reset mid-run
        fill_uniform(1, 2, 3, 0, 0);
        begin_pass(1'b0);
        send_beat(0, 0);
        send_beat(0, 1);
        send_beat(1, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_idx", 64'(idx_out), 64'(0));
        check("arst_max", 64'(max_out), 64'(0));
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_pixel_ready", 64'(pixel_ready), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_random();
        run_pass(1'b1, 20, 1'b1, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
